// File: rtl/cap_resp_pkg.sv
// Shared types and helpers for the capture gain/data responder.
// Latency: n/a (types, constants and elaboration-time helpers only).
// Backpressure: n/a.
package cap_resp_pkg;

    typedef enum logic [2:0] {
        G_IDLE,
        G_SHIFT,
        G_SETTLE,
        G_DONE,
        G_WAIT
    } gain_state_e;

    typedef enum logic [1:0] {
        D_IDLE,
        D_CAP,
        D_WAIT
    } data_state_e;

    localparam int SCLK_DIV_DEF = 4;
    localparam int PGA_W_DEF    = 8;

    // Cycles from chip-select assertion to the last falling sclk edge.
    localparam int FRAME_CYC = 2 * SCLK_DIV_DEF * PGA_W_DEF;

    function automatic int frame_cyc(input int sclk_div, input int pga_w);
        return 2 * sclk_div * pga_w;
    endfunction

    // True when an unsigned counter of cnt_w bits can represent value.
    function automatic bit cnt_fits(input int cnt_w, input int value);
        if (cnt_w >= 32) begin
            return 1'b1;
        end
        return longint'(value) <= ((longint'(1) << cnt_w) - 1);
    endfunction

endpackage

// File: rtl/pga_serial_tx.sv
// Serial PGA programmer: SPI mode 0, MSB first, one frame of PGA_W bits per start.
// Latency: cs_n falls on the start edge, frame ends 2*SCLK_DIV*PGA_W cycles later.
// Backpressure: none; start is ignored while a frame is in flight.
module pga_serial_tx #(
    parameter int PGA_W    = 8,
    parameter int SCLK_DIV = 4
) (
    input  logic             clk125,
    input  logic             rst,
    input  logic             start,
    input  logic [PGA_W-1:0] code,
    output logic             cs_n,
    output logic             sclk,
    output logic             sdi,
    output logic             done
);

    localparam int DIV_W = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
    localparam int BIT_W = (PGA_W > 1) ? $clog2(PGA_W) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(PGA_W - 1);

    logic             active_q, active_d;
    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [PGA_W-1:0] shreg_q, shreg_d;
    logic             cs_n_q, cs_n_d;
    logic             sclk_q, sclk_d;
    logic             sdi_q, sdi_d;
    logic             half_tick;

    // Half-period divider toggles sclk; data moves on falling edges, done flags the last one.
    always_comb begin
        active_d  = active_q;
        div_cnt_d = div_cnt_q;
        bit_cnt_d = bit_cnt_q;
        shreg_d   = shreg_q;
        cs_n_d    = cs_n_q;
        sclk_d    = sclk_q;
        sdi_d     = sdi_q;
        half_tick = active_q && (div_cnt_q == DIV_LAST);
        done      = half_tick && sclk_q && (bit_cnt_q == BIT_LAST);

        if (start && !active_q) begin
            active_d  = 1'b1;
            div_cnt_d = '0;
            bit_cnt_d = '0;
            cs_n_d    = 1'b0;
            sclk_d    = 1'b0;
            sdi_d     = code[PGA_W-1];
            shreg_d   = code << 1;
        end else if (active_q) begin
            div_cnt_d = half_tick ? '0 : div_cnt_q + 1'b1;
            if (half_tick) begin
                sclk_d = ~sclk_q;
                if (sclk_q) begin
                    if (bit_cnt_q == BIT_LAST) begin
                        active_d = 1'b0;
                        cs_n_d   = 1'b1;
                        sclk_d   = 1'b0;
                        sdi_d    = 1'b0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                        sdi_d     = shreg_q[PGA_W-1];
                        shreg_d   = shreg_q << 1;
                    end
                end
            end
        end
    end

    // Frame state registers; reset drops any partial frame with cs_n released.
    always_ff @(posedge clk125) begin
        if (rst) begin
            active_q  <= 1'b0;
            div_cnt_q <= '0;
            bit_cnt_q <= '0;
            shreg_q   <= '0;
            cs_n_q    <= 1'b1;
            sclk_q    <= 1'b0;
            sdi_q     <= 1'b0;
        end else begin
            active_q  <= active_d;
            div_cnt_q <= div_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            shreg_q   <= shreg_d;
            cs_n_q    <= cs_n_d;
            sclk_q    <= sclk_d;
            sdi_q     <= sdi_d;
        end
    end

    assign cs_n = cs_n_q;
    assign sclk = sclk_q;
    assign sdi  = sdi_q;

endmodule

// File: rtl/cap_gain_data_resp.sv
// Answers the capture controller's gain and data handshakes: programs the PGA, then streams tagged ADC samples.
// Latency: gain_cmpt 2*SCLK_DIV*PGA_W+SETTLE_CYC cycles after gain_en is sampled; each sample appears 1 cycle after adc_valid.
// Backpressure: none; the controller holds each request level until its completion pulse, samples outside a round are dropped.
module cap_gain_data_resp
    import cap_resp_pkg::*;
#(
    parameter int GAIN_W     = 1,
    parameter int ADC_W      = 16,
    parameter int PGA_W      = 8,
    parameter int SCLK_DIV   = 4,
    parameter int SETTLE_CYC = 250,
    parameter int SAMPLE_NUM = 1024,
    parameter int CNT_W      = 16
) (
    input  logic                    clk125,
    input  logic                    rst,
    input  logic                    gain_en,
    input  logic [GAIN_W-1:0]       gain_value,
    output logic                    gain_cmpt,
    input  logic                    data_en,
    output logic                    data_cmpt,
    input  logic [ADC_W-1:0]        adc_data,
    input  logic                    adc_valid,
    output logic                    pga_cs_n,
    output logic                    pga_sclk,
    output logic                    pga_sdi,
    output logic [GAIN_W+ADC_W-1:0] dout_data,
    output logic                    dout_valid,
    output logic                    dout_last,
    output logic                    busy
);

    if (!cnt_fits(CNT_W, SAMPLE_NUM) || !cnt_fits(CNT_W, SETTLE_CYC)) begin : g_cnt_chk
        $error("CNT_W too small for SAMPLE_NUM or SETTLE_CYC");
    end

    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0] SAMPLE_LAST = CNT_W'(SAMPLE_NUM - 1);

    gain_state_e                gain_state_q, gain_state_d;
    data_state_e                data_state_q, data_state_d;
    logic [CNT_W-1:0]           settle_cnt_q, settle_cnt_d;
    logic [CNT_W-1:0]           smp_cnt_q, smp_cnt_d;
    logic [GAIN_W-1:0]          tag_q, tag_d;
    logic [GAIN_W+ADC_W-1:0]    dout_data_q, dout_data_d;
    logic                       dout_valid_q, dout_valid_d;
    logic                       dout_last_q, dout_last_d;
    logic                       data_cmpt_q, data_cmpt_d;
    logic                       busy_q, busy_d;
    logic                       tx_start;
    logic                       tx_done;
    logic [PGA_W-1:0]           tx_code;

    pga_serial_tx #(
        .PGA_W    (PGA_W),
        .SCLK_DIV (SCLK_DIV)
    ) u_pga_tx (
        .clk125 (clk125),
        .rst    (rst),
        .start  (tx_start),
        .code   (tx_code),
        .cs_n   (pga_cs_n),
        .sclk   (pga_sclk),
        .sdi    (pga_sdi),
        .done   (tx_done)
    );

    // Gain side: start frame and retag, settle after the last sclk fall, pulse, then wait for request release.
    always_comb begin
        gain_state_d = gain_state_q;
        settle_cnt_d = settle_cnt_q;
        tag_d        = tag_q;
        tx_start     = 1'b0;
        tx_code      = PGA_W'(gain_value);
        case (gain_state_q)
            G_IDLE: begin
                if (gain_en) begin
                    tx_start     = 1'b1;
                    tag_d        = gain_value;
                    gain_state_d = G_SHIFT;
                end
            end
            G_SHIFT: begin
                if (tx_done) begin
                    settle_cnt_d = '0;
                    gain_state_d = G_SETTLE;
                end
            end
            G_SETTLE: begin
                if (settle_cnt_q == SETTLE_LAST) begin
                    gain_state_d = G_DONE;
                end else begin
                    settle_cnt_d = settle_cnt_q + 1'b1;
                end
            end
            G_DONE: begin
                gain_state_d = G_WAIT;
            end
            G_WAIT: begin
                if (!gain_en) begin
                    gain_state_d = G_IDLE;
                end
            end
            default: begin
                gain_state_d = G_IDLE;
            end
        endcase
    end

    // Data side: forward tagged samples during a round, flag the final one, then wait for request release.
    always_comb begin
        data_state_d = data_state_q;
        smp_cnt_d    = smp_cnt_q;
        dout_data_d  = dout_data_q;
        dout_valid_d = 1'b0;
        dout_last_d  = 1'b0;
        data_cmpt_d  = 1'b0;
        case (data_state_q)
            D_IDLE: begin
                if (data_en) begin
                    smp_cnt_d    = '0;
                    data_state_d = D_CAP;
                end
            end
            D_CAP: begin
                if (adc_valid) begin
                    dout_data_d  = {tag_q, adc_data};
                    dout_valid_d = 1'b1;
                    smp_cnt_d    = smp_cnt_q + 1'b1;
                    if (smp_cnt_q == SAMPLE_LAST) begin
                        dout_last_d  = 1'b1;
                        data_cmpt_d  = 1'b1;
                        data_state_d = D_WAIT;
                    end
                end
            end
            D_WAIT: begin
                if (!data_en) begin
                    data_state_d = D_IDLE;
                end
            end
            default: begin
                data_state_d = D_IDLE;
            end
        endcase
        busy_d = (gain_state_d != G_IDLE) || (data_state_d != D_IDLE);
    end

    // Gain FSM, settle counter and tag registers.
    always_ff @(posedge clk125) begin
        if (rst) begin
            gain_state_q <= G_IDLE;
            settle_cnt_q <= '0;
            tag_q        <= '0;
        end else begin
            gain_state_q <= gain_state_d;
            settle_cnt_q <= settle_cnt_d;
            tag_q        <= tag_d;
        end
    end

    // Data FSM, sample counter, output beat and busy registers.
    always_ff @(posedge clk125) begin
        if (rst) begin
            data_state_q <= D_IDLE;
            smp_cnt_q    <= '0;
            dout_data_q  <= '0;
            dout_valid_q <= 1'b0;
            dout_last_q  <= 1'b0;
            data_cmpt_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            data_state_q <= data_state_d;
            smp_cnt_q    <= smp_cnt_d;
            dout_data_q  <= dout_data_d;
            dout_valid_q <= dout_valid_d;
            dout_last_q  <= dout_last_d;
            data_cmpt_q  <= data_cmpt_d;
            busy_q       <= busy_d;
        end
    end

    assign gain_cmpt  = (gain_state_q == G_DONE);
    assign data_cmpt  = data_cmpt_q;
    assign dout_data  = dout_data_q;
    assign dout_valid = dout_valid_q;
    assign dout_last  = dout_last_q;
    assign busy       = busy_q;

endmodule
